kilit_sirali_denetleyici: RTL and testbench

//  Sequences step entry for the two-lock combination unit. Accepts one step per handshake in

---
 rtl/kilit_sirali_denetleyici.sv | 193 +++++++++++++++++++
 tb/tb_kilit_sirali_denetleyici.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kilit_sirali_denetleyici.sv
// kilit_sirali_denetleyici
// Step-entry sequencer for the two-lock combination unit.
// It accepts four steps in order (sag1, sol1, sag2, sol2) and packs them for the external
// comparator. It then samples the comparator result and manages three things: the
// failed-attempt count, the lockout period and the timed open window.
// Optional feature: define ZAMAN_ASIMI_EN to abandon a partial entry after ZAMAN_ASIMI
// idle cycles between steps.
module kilit_sirali_denetleyici #(
    parameter int MAX_DENEME   = 3,
    parameter int KILIT_SURESI = 1000,
    parameter int ACIK_SURESI  = 500,
    parameter int ZAMAN_ASIMI  = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                adim_gecerli,
    input  logic [2:0]                          adim_deger,
    output logic                                adim_hazir,
    input  logic                                iptal,
    input  logic                                kilitle,
    output logic [5:0]                          sag_adimlar,
    output logic [3:0]                          sol_adimlar,
    input  logic                                kilitler_acik_in,
    output logic                                kilit_acik,
    output logic                                kilitli,
    output logic                                hata,
    output logic [$clog2(MAX_DENEME+1)-1:0]     deneme_sayisi
);

    localparam int DW   = $clog2(MAX_DENEME + 1);
    localparam int TMAX = (KILIT_SURESI > ACIK_SURESI) ? KILIT_SURESI : ACIK_SURESI;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SAYAC_SIFIR = {TW{1'b0}};
    localparam logic [TW-1:0] SAYAC_BIR   = TW'(1);
    localparam logic [TW-1:0] ACIK_YUK    = TW'(ACIK_SURESI - 1);
    localparam logic [TW-1:0] KILIT_YUK   = TW'(KILIT_SURESI - 1);
    localparam logic [DW-1:0] DENEME_MAX  = DW'(MAX_DENEME);
    localparam logic [DW-1:0] DENEME_BIR  = DW'(1);

    typedef enum logic [2:0] {
        S_SAG1    = 3'd0,
        S_SOL1    = 3'd1,
        S_SAG2    = 3'd2,
        S_SOL2    = 3'd3,
        S_KONTROL = 3'd4,
        S_ACIK    = 3'd5,
        S_KILITLI = 3'd6
    } durum_t;

    durum_t          r_durum;
    logic [TW-1:0]   r_sayac;        // shared open-window / lockout down-counter
    logic            w_kabul;
    logic            w_zaman_asimi;
    logic [DW-1:0]   w_deneme_yeni;

    assign w_kabul       = adim_gecerli & adim_hazir;
    // Saturating increment; the count never wraps past MAX_DENEME.
    assign w_deneme_yeni = (deneme_sayisi >= DENEME_MAX) ? deneme_sayisi
                                                         : (deneme_sayisi + DENEME_BIR);

`ifdef ZAMAN_ASIMI_EN
    localparam int ZW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [ZW-1:0] BOS_SON = ZW'(ZAMAN_ASIMI - 1);
    localparam logic [ZW-1:0] BOS_BIR = ZW'(1);

    logic [ZW-1:0] r_bos;
    logic          w_ara_adim;

    // The timer only guards the gaps between steps, never the wait for the first step.
    assign w_ara_adim    = (r_durum == S_SOL1) || (r_durum == S_SAG2) || (r_durum == S_SOL2);
    assign w_zaman_asimi = w_ara_adim && !w_kabul && !iptal && (r_bos == BOS_SON);

    // Inter-step idle counter: restarts on every accepted step or on leaving the entry states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bos <= {ZW{1'b0}};
        end else if (w_ara_adim && !w_kabul && !iptal && !w_zaman_asimi) begin
            r_bos <= r_bos + BOS_BIR;
        end else begin
            r_bos <= {ZW{1'b0}};
        end
    end
`else
    assign w_zaman_asimi = 1'b0;
`endif

    // Main sequencer: state, step registers, timers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum       <= S_SAG1;
            r_sayac       <= SAYAC_SIFIR;
            adim_hazir    <= 1'b1;
            sag_adimlar   <= 6'd0;
            sol_adimlar   <= 4'd0;
            kilit_acik    <= 1'b0;
            kilitli       <= 1'b0;
            hata          <= 1'b0;
            deneme_sayisi <= {DW{1'b0}};
        end else begin
            hata <= 1'b0;
            case (r_durum)
                S_SAG1, S_SOL1, S_SAG2, S_SOL2: begin
                    // Abort beats a simultaneous step: the step is simply dropped.
                    if (iptal || w_zaman_asimi) begin
                        r_durum     <= S_SAG1;
                        sag_adimlar <= 6'd0;
                        sol_adimlar <= 4'd0;
                        adim_hazir  <= 1'b1;
                    end else if (w_kabul) begin
                        case (r_durum)
                            S_SAG1: begin
                                sag_adimlar[5:3] <= adim_deger;
                                r_durum          <= S_SOL1;
                            end
                            S_SOL1: begin
                                sol_adimlar[3:2] <= adim_deger[1:0];
                                r_durum          <= S_SAG2;
                            end
                            S_SAG2: begin
                                sag_adimlar[2:0] <= adim_deger;
                                r_durum          <= S_SOL2;
                            end
                            S_SOL2: begin
                                sol_adimlar[1:0] <= adim_deger[1:0];
                                r_durum          <= S_KONTROL;
                                adim_hazir       <= 1'b0;
                            end
                            default: begin
                                r_durum    <= S_SAG1;
                                adim_hazir <= 1'b1;
                            end
                        endcase
                    end else begin
                        adim_hazir <= 1'b1;
                    end
                end
                // The comparator sees the packed steps for one full cycle here.
                S_KONTROL: begin
                    if (kilitler_acik_in) begin
                        r_durum       <= S_ACIK;
                        kilit_acik    <= 1'b1;
                        deneme_sayisi <= {DW{1'b0}};
                        r_sayac       <= ACIK_YUK;
                    end else begin
                        hata          <= 1'b1;
                        sag_adimlar   <= 6'd0;
                        sol_adimlar   <= 4'd0;
                        deneme_sayisi <= w_deneme_yeni;
                        if (w_deneme_yeni == DENEME_MAX) begin
                            r_durum <= S_KILITLI;
                            kilitli <= 1'b1;
                            r_sayac <= KILIT_YUK;
                        end else begin
                            r_durum    <= S_SAG1;
                            adim_hazir <= 1'b1;
                        end
                    end
                end
                S_ACIK: begin
                    if (kilitle || (r_sayac == SAYAC_SIFIR)) begin
                        r_durum     <= S_SAG1;
                        kilit_acik  <= 1'b0;
                        sag_adimlar <= 6'd0;
                        sol_adimlar <= 4'd0;
                        adim_hazir  <= 1'b1;
                    end else begin
                        r_sayac <= r_sayac - SAYAC_BIR;
                    end
                end
                S_KILITLI: begin
                    if (r_sayac == SAYAC_SIFIR) begin
                        r_durum       <= S_SAG1;
                        kilitli       <= 1'b0;
                        deneme_sayisi <= {DW{1'b0}};
                        adim_hazir    <= 1'b1;
                    end else begin
                        r_sayac <= r_sayac - SAYAC_BIR;
                    end
                end
                default: begin
                    r_durum     <= S_SAG1;
                    kilit_acik  <= 1'b0;
                    kilitli     <= 1'b0;
                    sag_adimlar <= 6'd0;
                    sol_adimlar <= 4'd0;
                    adim_hazir  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kilit_sirali_denetleyici.sv
// Self-checking bench for kilit_sirali_denetleyici.
// Entries are predicted one whole attempt at a time: the expected packed value, the match
// decision, the attempt count and the open/lockout durations come from the rules directly.
module tb_kilit_sirali_denetleyici;

    localparam int MAX = 3;
    localparam int KS  = 1000;
    localparam int AS  = 500;
    localparam int ZA  = 256;

    logic       clk;
    logic       rst_n;
    logic       adim_gecerli;
    logic [2:0] adim_deger;
    logic       adim_hazir;
    logic       iptal;
    logic       kilitle;
    logic [5:0] sag_adimlar;
    logic [3:0] sol_adimlar;
    logic       kilitler_acik_in;
    logic       kilit_acik;
    logic       kilitli;
    logic       hata;
    logic [1:0] deneme_sayisi;

    int total = 0;
    int bad   = 0;
    int m_den = 0;   // reference model: failed attempts so far

    kilit_sirali_denetleyici #(
        .MAX_DENEME(MAX), .KILIT_SURESI(KS), .ACIK_SURESI(AS), .ZAMAN_ASIMI(ZA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adim_gecerli(adim_gecerli), .adim_deger(adim_deger),
        .adim_hazir(adim_hazir), .iptal(iptal), .kilitle(kilitle),
        .sag_adimlar(sag_adimlar), .sol_adimlar(sol_adimlar),
        .kilitler_acik_in(kilitler_acik_in), .kilit_acik(kilit_acik), .kilitli(kilitli),
        .hata(hata), .deneme_sayisi(deneme_sayisi)
    );

    assign kilitler_acik_in = (sag_adimlar == 6'o53) && (sol_adimlar == 4'b1001);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_kontrol(input string t);
        chk({t, "_hazir"},  32'(adim_hazir),    32'd1);
        chk({t, "_sag"},    32'(sag_adimlar),   32'd0);
        chk({t, "_sol"},    32'(sol_adimlar),   32'd0);
        chk({t, "_acik"},   32'(kilit_acik),    32'd0);
        chk({t, "_kilitli"},32'(kilitli),       32'd0);
        chk({t, "_hata"},   32'(hata),          32'd0);
        chk({t, "_deneme"}, 32'(deneme_sayisi), 32'd0);
    endtask

    task automatic bekle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One step presented for exactly one cycle; the DUT must be ready for it.
    task automatic step(input logic [2:0] v, input logic ip);
        chk("step_hazir", 32'(adim_hazir), 32'd1);
        adim_gecerli = 1'b1;
        adim_deger   = v;
        iptal        = ip;
        @(posedge clk); #1;
        adim_gecerli = 1'b0;
        iptal        = 1'b0;
    endtask

    // Full attempt. ip_idx: step carrying iptal (-1 none). kl: open cycle index (0-based)
    // at which kilitle is raised (-1 none). rst_at: lockout cycle to pull rst_n (-1 none).
    task automatic deneme_yap(input logic [2:0] a0, a1, a2, a3,
                              input int ip_idx, input int kl, input int rst_at);
        logic [2:0] v [4];
        logic [5:0] e_sag;
        logic [3:0] e_sol;
        int n;
        v = '{a0, a1, a2, a3};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) bekle($urandom_range(0, 2));
            if (i == ip_idx) begin
                step(v[i], 1'b1);
                chk("iptal_hazir",  32'(adim_hazir),    32'd1);
                chk("iptal_sag",    32'(sag_adimlar),   32'd0);
                chk("iptal_sol",    32'(sol_adimlar),   32'd0);
                chk("iptal_deneme", 32'(deneme_sayisi), 32'(m_den));
                return;
            end
            step(v[i], 1'b0);
        end
        e_sag = {v[0], v[2]};
        e_sol = {v[1][1:0], v[3][1:0]};
        chk("paket_sag",   32'(sag_adimlar), 32'(e_sag));
        chk("paket_sol",   32'(sol_adimlar), 32'(e_sol));
        chk("kontrol_hazir", 32'(adim_hazir), 32'd0);
        @(posedge clk); #1;
        if (e_sag == 6'o53 && e_sol == 4'b1001) begin
            m_den = 0;
            chk("acik",        32'(kilit_acik),    32'd1);
            chk("acik_hata",   32'(hata),          32'd0);
            chk("acik_deneme", 32'(deneme_sayisi), 32'd0);
            n = 0;
            while (kilit_acik === 1'b1 && n < 3000) begin
                kilitle = (n == kl);
                @(posedge clk); #1;
                kilitle = 1'b0;
                n++;
            end
            chk("acik_sure", 32'(n), (kl >= 0) ? 32'(kl + 1) : 32'(AS));
            chk("acik_son_sag",   32'(sag_adimlar), 32'd0);
            chk("acik_son_hazir", 32'(adim_hazir),  32'd1);
        end else begin
            if (m_den < MAX) m_den++;
            chk("hata_darbe",  32'(hata),          32'd1);
            chk("hata_acik",   32'(kilit_acik),    32'd0);
            chk("hata_deneme", 32'(deneme_sayisi), 32'(m_den));
            chk("hata_sag",    32'(sag_adimlar),   32'd0);
            chk("hata_sol",    32'(sol_adimlar),   32'd0);
            if (m_den == MAX) begin
                chk("kilitli",       32'(kilitli),    32'd1);
                chk("kilitli_hazir", 32'(adim_hazir), 32'd0);
                n = 0;
                while (kilitli === 1'b1 && n < 3000) begin
                    if (n == rst_at) begin
                        adim_gecerli = 1'b0;
                        iptal        = 1'b0;
                        #3 rst_n = 1'b0;
                        #1 reset_kontrol("kilitli_reset");
                        @(negedge clk) rst_n = 1'b1;
                        @(posedge clk); #1;
                        m_den = 0;
                        return;
                    end
                    adim_gecerli = 1'($urandom_range(0, 1));
                    adim_deger   = 3'($urandom_range(0, 7));
                    iptal        = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    n++;
                    if (n == 1) chk("kilitli_hata_tek", 32'(hata), 32'd0);
                    chk("kilitli_hazir_yok", 32'(adim_hazir), 32'(!kilitli));
                end
                adim_gecerli = 1'b0;
                iptal        = 1'b0;
                m_den = 0;
                chk("kilit_sure",       32'(n),             32'(KS));
                chk("kilit_son_deneme", 32'(deneme_sayisi), 32'd0);
                chk("kilit_son_hazir",  32'(adim_hazir),    32'd1);
            end else begin
                chk("hata_hazir", 32'(adim_hazir), 32'd1);
                @(posedge clk); #1;
                chk("hata_tek", 32'(hata), 32'd0);
            end
        end
    endtask

    initial begin
        int hsay;
        logic [2:0] r0, r1, r2, r3;
        int sel, ipi, kli;

        rst_n        = 1'b1;
        adim_gecerli = 1'b0;
        adim_deger   = 3'd0;
        iptal        = 1'b0;
        kilitle      = 1'b0;
        #2 rst_n = 1'b0;
        #2 reset_kontrol("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        reset_kontrol("reset_sonra");

        // 1) correct combination, full open window
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd1, -1, -1, -1);
        // 2) wrong combination
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd0, -1, -1, -1);
        // 3) two more wrong entries reach the lockout
        deneme_yap(3'd7, 3'd1, 3'd0, 3'd2, -1, -1, -1);
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd3, -1, -1, -1);
        // 4) one wrong, then abort on the third step keeps the count, then open
        deneme_yap(3'd1, 3'd1, 3'd1, 3'd1, -1, -1, -1);
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd1, 2, -1, -1);
        deneme_yap(3'd5, 3'd6, 3'd3, 3'd5, -1, -1, -1);   // bit 2 of sol steps ignored
        // 5) relock at open cycle 10, then reset in the middle of a lockout
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd1, -1, 10, -1);
        deneme_yap(3'd0, 3'd0, 3'd0, 3'd0, -1, -1, -1);
        deneme_yap(3'd0, 3'd0, 3'd0, 3'd1, -1, -1, -1);
        deneme_yap(3'd0, 3'd0, 3'd0, 3'd2, -1, -1, 300);
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd1, -1, 0, -1);

        // randomized attempts
        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                r0 = 3'd5;
                r1 = {1'($urandom_range(0, 1)), 2'b10};
                r2 = 3'd3;
                r3 = {1'($urandom_range(0, 1)), 2'b01};
            end else begin
                r0 = 3'($urandom_range(0, 7));
                r1 = 3'($urandom_range(0, 7));
                r2 = 3'($urandom_range(0, 7));
                r3 = 3'($urandom_range(0, 7));
            end
            ipi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            kli = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
            deneme_yap(r0, r1, r2, r3, ipi, kli, -1);
        end

        // 6) long idle gap after the first step
        step(3'd5, 1'b0);
        hsay = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (hata !== 1'b0) hsay++;
        end
        chk("bos_hata",   32'(hsay),          32'd0);
        chk("bos_deneme", 32'(deneme_sayisi), 32'(m_den));
        chk("bos_hazir",  32'(adim_hazir),    32'd1);
`ifdef ZAMAN_ASIMI_EN
        chk("zaman_asimi_sag", 32'(sag_adimlar), 32'd0);
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd1, -1, 5, -1);
`else
        chk("bekleyen_sag", 32'(sag_adimlar), 32'(6'o50));
        deneme_yap(3'd2, 3'd3, 3'd1, 3'd0, 0, -1, -1);
        deneme_yap(3'd5, 3'd2, 3'd3, 3'd1, -1, 5, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
